// File: rtl/ascon_permutation.sv
// ascon_permutation
//   Iterative Ascon permutation (p^a / p^b), one round per clock.
//   The controller presents a 320-bit state and a round count with a start
//   pulse; the core runs the last n rounds of p^12 and pulses done when the
//   permuted state is available on state_out.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start       request a permutation, sampled only while idle
//   num_rounds  rounds to apply (12 = p^a, 6 = p^b); values above 12 clamp
//   state_in    state to permute, x0 = [319:256] ... x4 = [63:0]
//   state_out   state register; result valid while done=1, held until next start
//   busy        high while a permutation is in progress
//   done        single-cycle pulse when the result is ready
module ascon_permutation #(
    parameter int unsigned MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   num_rounds,
    input  logic [319:0] state_in,
    output logic [319:0] state_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {StIdle, StRun} fsm_e;

    localparam logic [3:0] MaxRounds = 4'(MAX_ROUNDS);

    fsm_e         fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   remaining_q, remaining_d;
    logic         done_q, done_d;
    logic [3:0]   n_eff;
    logic         last;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One full Ascon round: constant addition, bitsliced S-box, linear layer.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [7:0]  c;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        c  = {4'hF - r, r};
        x2[7:0] = x2[7:0] ^ c;
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    assign n_eff = (num_rounds > MaxRounds) ? MaxRounds : num_rounds;
    // A zero-round request also finishes on its first RUN cycle.
    assign last  = (remaining_q <= 4'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            round_q     <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_q     <= round_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_d     = round_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    fsm_d       = StRun;
                    state_d     = state_in;
                    round_d     = MaxRounds - n_eff;
                    remaining_d = n_eff;
                end
            end
            StRun: begin
                if (remaining_q != 4'd0) begin
                    state_d     = ascon_round(state_q, round_q);
                    round_d     = round_q + 4'd1;
                    remaining_d = remaining_q - 4'd1;
                end
                if (last) begin
                    fsm_d  = StIdle;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        state_out = state_q;
        busy      = (fsm_q == StRun);
        done      = done_q;
    end

endmodule

// File: tb/tb_ascon_permutation.sv
module tb_ascon_permutation;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   num_rounds;
    logic [319:0] state_in;
    logic [319:0] state_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    ascon_permutation #(.MAX_ROUNDS(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_rounds (num_rounds),
        .state_in   (state_in),
        .state_out  (state_out),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [319:0] s;
        logic [3:0]   n;
        logic [319:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference: last n rounds of p^12, working on a word array.
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [63:0] x[5];
        logic [63:0] t[5];
        int rot_a[5] = '{19, 61, 1, 10, 7};
        int rot_b[5] = '{28, 39, 6, 17, 41};
        int ne;
        ne = (n > 12) ? 12 : n;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - ne; r < 12; r++) begin
            x[2] ^= 64'(8'(8'hF0 - r * 15));
            x[0] ^= x[4];
            x[4] ^= x[3];
            x[2] ^= x[1];
            for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
            for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
            x[1] ^= x[0];
            x[0] ^= x[4];
            x[3] ^= x[2];
            x[2] = ~x[2];
            for (int i = 0; i < 5; i++) x[i] ^= rotr(x[i], rot_a[i]) ^ rotr(x[i], rot_b[i]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Start a run on the next edge and follow it to done; back-to-back capable.
    task automatic run_vec(input string name, input logic [319:0] s, input logic [3:0] n,
                           input logic [319:0] exp, input int lat);
        int k;
        int busy_cnt;
        @(negedge clk);
        state_in   = s;
        num_rounds = n;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        state_in   = rand320();
        num_rounds = 4'($urandom_range(0, 15));
        chk({name, "_done_low_at_start"}, done, 0);
        k = 0;
        busy_cnt = 0;
        while (!done && k < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, "_latency"}, k, lat);
        chk({name, "_busy_cycles"}, busy_cnt, lat);
        chk({name, "_busy_low_at_done"}, busy, 0);
        chk({name, "_state"}, state_out, exp);
    endtask

    initial begin
        logic [319:0] s;
        logic [319:0] cap;
        int dones;
        int k;
        int lat;

        rst_n      = 1'b0;
        start      = 1'b0;
        num_rounds = 4'd0;
        state_in   = '0;

        // Zero state, single round (constant 0x4B), hand-derived result.
        vecs[0] = '{s: '0, n: 4'd1, lat: 1,
                    exp: {64'h000964B00000004B, 64'h0000000096000213,
                          64'h53FFFFFFFFFFFF90, 64'h12E580000000004B, 64'h0}};
        s = {64'h80400c0600000000, 256'h0};
        vecs[1] = '{s: s, n: 4'd12, exp: ref_perm(s, 12), lat: 12};
        s = rand320();
        vecs[2] = '{s: s, n: 4'd6, exp: ref_perm(s, 6), lat: 6};
        s = rand320();
        vecs[3] = '{s: s, n: 4'd15, exp: ref_perm(s, 12), lat: 12};
        vecs[4] = '{s: s, n: 4'd12, exp: ref_perm(s, 12), lat: 12};
        s = rand320();
        vecs[5] = '{s: s, n: 4'd0, exp: s, lat: 1};
        s = rand320();
        vecs[6] = '{s: s, n: 4'd3, exp: ref_perm(s, 3), lat: 3};
        s = rand320();
        vecs[7] = '{s: s, n: 4'd9, exp: ref_perm(s, 9), lat: 9};

        #12;
        chk("reset_state", state_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        // Consecutive vectors start in each other's done cycle.
        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i].s, vecs[i].n,
                                            vecs[i].exp, vecs[i].lat);

        // Start held every cycle while busy with different data: only the first counts.
        @(negedge clk);
        s = rand320();
        cap = '0;
        state_in   = s;
        num_rounds = 4'd12;
        start      = 1'b1;
        dones = 0;
        lat = -1;
        for (k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                cap = state_out;
                if (lat < 0) lat = k;
            end
            @(negedge clk);
            start      = busy;
            state_in   = rand320();
            num_rounds = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        chk("spam_done_count", dones, 1);
        chk("spam_latency", lat, 12);
        chk("spam_state", cap, ref_perm(s, 12));

        // Reset in the middle of a p^12 run.
        @(negedge clk);
        state_in   = rand320();
        num_rounds = 4'd12;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_state", state_out, 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        chk("no_activity_after_reset", dones, 0);
        s = rand320();
        run_vec("after_reset", s, 4'd6, ref_perm(s, 6), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
